// File: rtl/int_to_fp_seq.sv
// Iterative integer to IEEE-754 converter: normalises one bit per cycle,
// rounds to nearest-even and hands the result off over a valid/ready pair.
module int_to_fp_seq #(
  parameter int IN_WIDTH  = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_WIDTH-1:0]                in_data,
  input  logic                               in_signed,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]       out_data,
  output logic                               out_inexact
);

  localparam int SH_W  = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;
  localparam int EXT_W = IN_WIDTH + MAN_WIDTH;
  // Biased exponent of an unshifted operand: (IN_WIDTH-1) + bias.
  localparam logic [EXP_WIDTH-1:0] EXP_BASE =
    EXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 1 + IN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                state, state_nxt;
  logic                  sign_q;
  logic [IN_WIDTH-1:0]   mag_q;
  logic [SH_W-1:0]       shift_q;
  logic                  accept;
  logic                  in_sign;
  logic [MAN_WIDTH+1:0]  rnd;
  logic [EXP_WIDTH-1:0]  exp_biased;

  // Round-to-nearest-even on the bits below the hidden one.
  // Returns {inexact, carry, fraction}; on carry the fraction is already zero.
  function automatic logic [MAN_WIDTH+1:0] round_rne(input logic [IN_WIDTH-2:0] m);
    logic [EXT_W-1:0]     ext;
    logic [MAN_WIDTH-1:0] frac;
    logic                 guard;
    logic                 sticky;
    logic                 up;
    logic [MAN_WIDTH:0]   inc;
    // Zero padding makes the narrow-input case fall out exact (guard/sticky = 0).
    ext    = {m, {(MAN_WIDTH + 1){1'b0}}};
    frac   = ext[EXT_W-1 -: MAN_WIDTH];
    guard  = ext[IN_WIDTH-1];
    sticky = |ext[IN_WIDTH-2:0];
    up     = guard && (sticky || frac[0]);
    inc    = {1'b0, frac} + (MAN_WIDTH + 1)'(up);
    return {guard | sticky, inc};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign in_sign   = in_signed & in_data[IN_WIDTH-1];

  assign rnd        = round_rne(mag_q[IN_WIDTH-2:0]);
  assign exp_biased = EXP_BASE - EXP_WIDTH'(shift_q) + EXP_WIDTH'(rnd[MAN_WIDTH]);

  // Next-state logic for the conversion sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (in_data == '0) ? DONE : NORM;
      NORM:  if (mag_q[IN_WIDTH-1]) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers; reset discards any in-flight conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && in_data == '0) begin
        out_data    <= '0;
        out_inexact <= 1'b0;
      end else if (state == ROUND) begin
        out_data    <= {sign_q, exp_biased, rnd[MAN_WIDTH-1:0]};
        out_inexact <= rnd[MAN_WIDTH+1];
      end
    end
  end

  // Magnitude capture and one-bit-per-cycle normalising shifter.
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_q  <= in_sign;
      mag_q   <= in_sign ? -in_data : in_data;
      shift_q <= '0;
    end else if (state == NORM && !mag_q[IN_WIDTH-1]) begin
      mag_q   <= mag_q << 1;
      shift_q <= shift_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Directed bench for int_to_fp_seq with the default 32-bit / single-precision setup.
module tb_int_to_fp_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] din;
    logic        sgn;
    logic [31:0] dout;
    logic        inex;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  int_to_fp_seq #(.IN_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_signed  (in_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_inexact(out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Apply one operand with out_ready held high and check latency, result and handoff.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    logic got;
    @(negedge clk);
    chk($sformatf("v%0d in_ready_before", idx), {31'b0, in_ready}, 32'd1);
    in_data   = v.din;
    in_signed = v.sgn;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = $urandom;
    in_signed = 1'($urandom_range(0, 1));
    lat = 0;
    got = out_valid;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      got = out_valid;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d out_data", idx), out_data, v.dout);
    chk($sformatf("v%0d inexact", idx), {31'b0, out_inexact}, {31'b0, v.inex});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d handoff", idx), {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    vecs[0]  = '{32'h00000001, 1'b0, 32'h3F800000, 1'b0, 33};
    vecs[1]  = '{32'h7FFFFFFF, 1'b0, 32'h4F000000, 1'b1, 3};
    vecs[2]  = '{32'h80000000, 1'b0, 32'h4F000000, 1'b0, 2};
    vecs[3]  = '{32'h80000000, 1'b1, 32'hCF000000, 1'b0, 2};
    vecs[4]  = '{32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0, 33};
    vecs[5]  = '{32'h00000000, 1'b1, 32'h00000000, 1'b0, 0};
    vecs[6]  = '{32'h01000001, 1'b0, 32'h4B800000, 1'b1, 9};
    vecs[7]  = '{32'h01000003, 1'b0, 32'h4B800002, 1'b1, 9};
    vecs[8]  = '{32'h00000005, 1'b0, 32'h40A00000, 1'b0, 31};
    vecs[9]  = '{32'h00000000, 1'b0, 32'h00000000, 1'b0, 0};
    vecs[10] = '{32'h00000005, 1'b1, 32'h40A00000, 1'b0, 31};
    vecs[11] = '{32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1, 2};
    vecs[12] = '{32'hFFFFFFFB, 1'b1, 32'hC0A00000, 1'b0, 31};
    vecs[13] = '{32'h00FFFFFF, 1'b0, 32'h4B7FFFFF, 1'b0, 10};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_data", out_data, 32'h0);
    chk("reset inexact", {31'b0, out_inexact}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Backpressure: result must hold while the consumer stalls.
    @(negedge clk);
    out_ready = 1'b0;
    in_data   = 32'h01000003;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("bp latency", 32'(n), 32'd9);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid  = ~in_valid;
      in_data   = $urandom;
      in_signed = 1'(k);
      @(posedge clk);
      #1;
      chk($sformatf("bp hold data %0d", k), out_data, 32'h4B800002);
      chk($sformatf("bp hold ctrl %0d", k), {30'b0, out_valid, in_ready}, 32'b10);
    end
    chk("bp inexact", {31'b0, out_inexact}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release", {30'b0, out_valid, in_ready}, 32'b01);
    @(posedge clk);
    #1;
    chk("bp single handoff", {30'b0, out_valid, in_ready}, 32'b01);

    // Reset in the middle of normalisation.
    @(negedge clk);
    in_data   = 32'h00000001;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset ctrl", {30'b0, out_valid, in_ready}, 32'b01);
    chk("midreset data", out_data, 32'h0);
    chk("midreset inexact", {31'b0, out_inexact}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_vec('{32'h00000005, 1'b0, 32'h40A00000, 1'b0, 31}, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
